// File: rtl/intr_source_ctrl.sv
// Interrupt source controller: captures edge-triggered device requests,
// masks them, picks the lowest-index enabled request and presents it to the
// core as a registered intr level. It then walks the claim/complete
// handshake through a small memory-mapped register window.
module intr_source_ctrl #(
   parameter int N_SRC   = 8,
   parameter int GAP_CYC = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   output logic             intr,
   input  logic             intr_ack,
   input  logic [3:0]       addr,
   input  logic             we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic [4:0]       irq_id
);

   // Counter only ever holds GAP_CYC-1 down to 0.
   localparam int CNT_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t           state;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] src_q;
   logic [4:0]       id;
   logic [CNT_W-1:0] cnt;

   logic [1:0]       sel;
   logic             wr_pending;
   logic             wr_enable;
   logic             wr_complete;
   logic             ack_hit;
   logic             complete_hit;
   logic [N_SRC-1:0] src_rise;
   logic [N_SRC-1:0] ack_mask;
   logic [N_SRC-1:0] w1c_mask;
   logic [N_SRC-1:0] req;
   logic [4:0]       next_id;
   logic             unused_bits;

   // Lowest set index wins; returns index+1, or 0 when nothing requests.
   function automatic logic [4:0] pick_id(input logic [N_SRC-1:0] r);
      pick_id = 5'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (r[i]) pick_id = 5'(i + 1);
      end
   endfunction

   assign sel          = addr[3:2];
   assign wr_pending   = we && (sel == 2'd0);
   assign wr_enable    = we && (sel == 2'd1);
   assign wr_complete  = we && (sel == 2'd3);
   assign ack_hit      = (state == ASSERT) && intr_ack;
   assign complete_hit = (state == SERVICE) && wr_complete && (wdata[4:0] == id);
   assign src_rise     = src & ~src_q;
   assign ack_mask     = ack_hit ? (N_SRC'(1) << (id - 5'd1)) : '0;
   assign w1c_mask     = wr_pending ? wdata[N_SRC-1:0] : '0;
   assign req          = pending & enable;
   assign next_id      = pick_id(req);
   assign unused_bits  = ^{addr[1:0], wdata};

   // The claimed id is only visible while the request is outstanding.
   assign irq_id = ((state == ASSERT) || (state == SERVICE)) ? id : 5'd0;

   // Register read mux; unimplemented bits and COMPLETE read as zero.
   always_comb begin
      rdata = 32'd0;
      case (sel)
         2'd0:    rdata = 32'(pending);
         2'd1:    rdata = 32'(enable);
         2'd2:    rdata = {27'd0, irq_id};
         default: rdata = 32'd0;
      endcase
   end

   // Edge capture, pending/enable registers; a new edge beats any clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         enable  <= '0;
         src_q   <= '0;
      end else begin
         src_q   <= src;
         pending <= (pending & ~(w1c_mask | ack_mask)) | src_rise;
         if (wr_enable) enable <= wdata[N_SRC-1:0];
      end
   end

   // Request/ack/complete handshake with a guaranteed low gap on intr.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         intr  <= 1'b0;
         id    <= 5'd0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  id    <= next_id;
                  intr  <= 1'b1;
                  state <= ASSERT;
               end
            end
            ASSERT: begin
               if (intr_ack) begin
                  intr  <= 1'b0;
                  state <= SERVICE;
               end
            end
            SERVICE: begin
               if (complete_hit) begin
                  cnt   <= CNT_W'(GAP_CYC - 1);
                  state <= GAP;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  id    <= 5'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               intr  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Bench for intr_source_ctrl: directed walk through the request, masking,
// conflict and reset scenarios, then a long randomized run, all checked
// cycle by cycle against a transaction-level model of the controller.
module tb_intr_source_ctrl;

   localparam int N = 8;
   localparam int G = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  src;
   logic          intr;
   logic          intr_ack;
   logic [3:0]    addr;
   logic          we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [4:0]    irq_id;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending/enable sets, the claimed request, whether it
   // is still being signalled, and how many quiet cycles remain after it.
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_en   = '0;
   logic [N-1:0] m_prev = '0;
   int           m_claim = 0;
   bit           m_asrt  = 1'b0;
   int           m_gap   = 0;

   intr_source_ctrl #(.N_SRC(N), .GAP_CYC(G)) dut (
      .clk      (clk),
      .reset    (reset),
      .src      (src),
      .intr     (intr),
      .intr_ack (intr_ack),
      .addr     (addr),
      .we       (we),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq_id   (irq_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_id();
      return (m_gap > 0) ? 0 : m_claim;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [3:0] ad);
      case (ad[3:2])
         2'd0:    return 32'(m_pend);
         2'd1:    return 32'(m_en);
         2'd2:    return 32'(exp_id());
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_update(input logic r, input logic [N-1:0] s, input logic a,
                               input logic w, input logic [3:0] ad, input logic [31:0] wd);
      logic [N-1:0] clr;
      logic [N-1:0] en_n;
      logic [N-1:0] want;
      int           claim_n;
      bit           asrt_n;
      int           gap_n;
      bit           found;
      if (r) begin
         m_pend = '0; m_en = '0; m_prev = '0;
         m_claim = 0; m_asrt = 1'b0; m_gap = 0;
         return;
      end
      clr = '0; en_n = m_en; claim_n = m_claim; asrt_n = m_asrt; gap_n = m_gap;
      if (w && ad[3:2] == 2'd0) clr = wd[N-1:0];
      if (w && ad[3:2] == 2'd1) en_n = wd[N-1:0];
      if (m_gap > 0) begin
         gap_n = m_gap - 1;
         if (gap_n == 0) claim_n = 0;
      end else if (m_claim == 0) begin
         want = m_pend & m_en;
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (want[i] && !found) begin
               found = 1'b1;
               claim_n = i + 1;
               asrt_n = 1'b1;
            end
         end
      end else if (m_asrt) begin
         if (a) begin
            clr[m_claim-1] = 1'b1;
            asrt_n = 1'b0;
         end
      end else if (w && ad[3:2] == 2'd3 && int'(wd[4:0]) == m_claim) begin
         gap_n = G;
      end
      m_pend  = (m_pend & ~clr) | (s & ~m_prev);
      m_prev  = s;
      m_en    = en_n;
      m_claim = claim_n;
      m_asrt  = asrt_n;
      m_gap   = gap_n;
   endtask

   // One clock cycle: drive at the falling edge, check the read path, let the
   // rising edge happen, advance the model and check the registered outputs.
   task automatic step(input logic r, input logic [N-1:0] s, input logic a,
                       input logic w, input logic [3:0] ad, input logic [31:0] wd);
      reset = r; src = s; intr_ack = a; we = w; addr = ad; wdata = wd;
      #1;
      chk("rdata", rdata, exp_rdata(ad));
      @(posedge clk);
      model_update(r, s, a, w, ad, wd);
      @(negedge clk);
      chk("intr", 32'(intr), 32'(m_asrt));
      chk("irq_id", 32'(irq_id), 32'(exp_id()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 4'h8, 32'd0);
   endtask

   task automatic wr(input logic [3:0] ad, input logic [31:0] wd);
      step(1'b0, '0, 1'b0, 1'b1, ad, wd);
   endtask

   initial begin
      int          low;
      bit          seen;
      logic [N-1:0] src_r;
      logic        r_r, a_r, w_r;
      logic [3:0]  ad_r;
      logic [31:0] wd_r;

      reset = 1'b1; src = '0; intr_ack = 1'b0; addr = 4'h0; we = 1'b0; wdata = 32'd0;
      @(posedge clk);
      @(negedge clk);
      step(1'b1, '0, 1'b0, 1'b0, 4'h0, 32'd0);
      chk("rst_intr", 32'(intr), 32'd0);
      chk("rst_id", 32'(irq_id), 32'd0);
      chk("rst_pend", rdata, 32'd0);

      // Single request, ack, complete, gap.
      wr(4'h4, 32'h01);
      step(1'b0, 8'h01, 1'b0, 1'b0, 4'h0, 32'd0);
      chk("t1_pend", rdata, 32'h01);
      chk("t1_intr_k", 32'(intr), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      chk("t1_intr_k1", 32'(intr), 32'd1);
      chk("t1_claim", rdata, 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 32'd0);
      chk("t1_ack_intr", 32'(intr), 32'd0);
      chk("t1_ack_pend", rdata, 32'd0);
      chk("t1_ack_id", 32'(irq_id), 32'd1);
      wr(4'hC, 32'd1);
      idle(3);
      chk("t1_done_id", 32'(irq_id), 32'd0);

      // Two simultaneous requests: lower index first, then the other.
      wr(4'h4, 32'hFF);
      step(1'b0, 8'h24, 1'b0, 1'b0, 4'h8, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      chk("t2_first", rdata, 32'd3);
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h8, 32'd0);
      low = 1;
      wr(4'hC, 32'd3);
      low++;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle(1);
         if (intr === 1'b1) seen = 1'b1;
         else low++;
      end
      chk("t2_rearm", 32'(seen), 32'd1);
      chk("t2_second", 32'(irq_id), 32'd6);
      chk("t2_gap_ok", 32'(low >= G), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h8, 32'd0);
      wr(4'hC, 32'd6);
      idle(4);

      // Masking, then enabling a masked pending source.
      wr(4'h4, 32'h00);
      step(1'b0, 8'h02, 1'b0, 1'b0, 4'h0, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'd0);
      chk("t3_pend", rdata, 32'h02);
      chk("t3_masked", 32'(intr), 32'd0);
      wr(4'h4, 32'h02);
      idle(1);
      chk("t3_enabled", 32'(intr), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h8, 32'd0);
      wr(4'hC, 32'd2);
      idle(4);
      wr(4'h4, 32'h00);
      step(1'b0, 8'h02, 1'b0, 1'b0, 4'h8, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      wr(4'h0, 32'h02);
      wr(4'h4, 32'h02);
      idle(3);
      chk("t3_cleared", 32'(intr), 32'd0);

      // Re-event in the ack cycle survives; wrong complete id is ignored.
      wr(4'h4, 32'h08);
      step(1'b0, 8'h08, 1'b0, 1'b0, 4'h8, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      chk("t4_id", 32'(irq_id), 32'd4);
      step(1'b0, 8'h08, 1'b1, 1'b0, 4'h0, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'd0);
      chk("t4_pend_kept", rdata & 32'h08, 32'h08);
      wr(4'hC, 32'd7);
      chk("t4_bad_complete", 32'(irq_id), 32'd4);
      wr(4'hC, 32'd4);
      idle(4);
      chk("t4_reissue", 32'(intr), 32'd1);
      chk("t4_reissue_id", 32'(irq_id), 32'd4);

      // Reset while in service.
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h8, 32'd0);
      step(1'b1, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      chk("t5_intr", 32'(intr), 32'd0);
      chk("t5_claim", rdata, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 32'd0);
      chk("t5_pend", rdata, 32'd0);
      step(1'b0, 8'hFF, 1'b0, 1'b0, 4'h4, 32'd0);
      chk("t5_en", rdata, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h8, 32'd0);
      idle(3);
      chk("t5_ignored", 32'(intr), 32'd0);

      // Randomized traffic against the model.
      src_r = '0;
      for (int c = 0; c < 4000; c++) begin
         r_r   = ($urandom_range(0, 299) == 0);
         src_r = src_r ^ N'($urandom & $urandom & $urandom);
         a_r   = ($urandom_range(0, 2) == 0);
         w_r   = ($urandom_range(0, 3) == 0);
         ad_r  = 4'($urandom);
         case (ad_r[3:2])
            2'd0:    wd_r = $urandom & $urandom & $urandom;
            2'd1:    wd_r = $urandom;
            2'd3:    wd_r = ($urandom_range(0, 3) != 0) ? 32'(m_claim) : 32'($urandom_range(0, 31));
            default: wd_r = $urandom;
         endcase
         step(r_r, src_r, a_r, w_r, ad_r, wd_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
